// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Round-robin arbiter sharing one combinational ALU between NREQ (2..4)
//   requesters. The grant is combinational. The result, together with the
//   owning requester ID, is captured in a single response register that has
//   a valid/ready handshake.
//
// Optional feature macro: ALU_SHARE_ARB_OPCHECK_EN
//   defined   : illegal op codes return rsp_err=1 and rsp_result=0
//   undefined : rsp_err is tied to 0
//
// Ports
//   CLK, RST_N             clock, asynchronous active-low reset
//   req_valid[NREQ]        per-requester request valid
//   req_a/req_b[32*NREQ]   operands, requester i at [32i+31:32i]
//   req_fun[4*NREQ]        op code, requester i at [4i+3:4i]
//   req_ready[NREQ]        one-hot grant (all zero when nothing is granted)
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_result     owner index and registered ALU result
//   rsp_err                illegal op code flag
//   op_count               saturating count of accepted requests
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int NREQ = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_fun,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic [15:0]          op_count
);

    // Shared ALU; unknown codes produce zero.
    function automatic logic [31:0] alu_f(input logic [3:0] fun,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (fun)
            4'b0000: r = a + b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'd0, ($signed(a) < $signed(b))};
            4'b0011: r = {31'd0, (a < b)};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1000: r = a - b;
            4'b1001: r = a;
            4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // True for the op codes the ALU implements.
    function automatic logic op_legal_f(input logic [3:0] fun);
        logic ok;
        case (fun)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1101: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]      ptr_r;
    logic            rsp_valid_r;
    logic [1:0]      rsp_id_r;
    logic [31:0]     rsp_result_r;
    logic            rsp_err_r;
    logic [15:0]     op_count_r;

    logic            slot_free_s;
    logic            hit_hi_s;
    logic            hit_lo_s;
    logic [1:0]      idx_hi_s;
    logic [1:0]      idx_lo_s;
    logic [1:0]      grant_idx_s;
    logic [NREQ-1:0] grant_s;
    logic            xfer_s;
    logic [31:0]     a_s;
    logic [31:0]     b_s;
    logic [3:0]      fun_s;
    logic [31:0]     alu_res_s;
    logic            err_s;

    // Round-robin pick: lowest valid index at or above ptr, else lowest below.
    // Only valid bits, the slot state and ptr feed this path.
    always_comb begin
        slot_free_s = !rsp_valid_r || rsp_ready;
        hit_hi_s    = 1'b0;
        hit_lo_s    = 1'b0;
        idx_hi_s    = 2'd0;
        idx_lo_s    = 2'd0;
        // Descending loops so the lowest qualifying index wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(ptr_r))) begin
                hit_hi_s = 1'b1;
                idx_hi_s = 2'(i);
            end else begin
                hit_hi_s = hit_hi_s;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(ptr_r))) begin
                hit_lo_s = 1'b1;
                idx_lo_s = 2'(i);
            end else begin
                hit_lo_s = hit_lo_s;
            end
        end
        if (hit_hi_s) begin
            grant_idx_s = idx_hi_s;
        end else begin
            grant_idx_s = idx_lo_s;
        end
        // Grants are suppressed while reset is held.
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i] = RST_N && slot_free_s && (hit_hi_s || hit_lo_s) &&
                         (grant_idx_s == 2'(i));
        end
        xfer_s = |grant_s;
    end

    // Payload mux from the granted requester into the ALU.
    always_comb begin
        a_s   = 32'd0;
        b_s   = 32'd0;
        fun_s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == 2'(i)) begin
                a_s   = req_a[32*i +: 32];
                b_s   = req_b[32*i +: 32];
                fun_s = req_fun[4*i +: 4];
            end else begin
                a_s = a_s;
            end
        end
        alu_res_s = alu_f(fun_s, a_s, b_s);
`ifdef ALU_SHARE_ARB_OPCHECK_EN
        err_s = !op_legal_f(fun_s);
`else
        err_s = 1'b0;
`endif
    end

    // Response register, round-robin pointer and saturating op counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r        <= 2'd0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 2'd0;
            rsp_result_r <= 32'd0;
            rsp_err_r    <= 1'b0;
            op_count_r   <= 16'd0;
        end else begin
            if (xfer_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_id_r     <= grant_idx_s;
                rsp_result_r <= alu_res_s;
                rsp_err_r    <= err_s;
                ptr_r        <= (grant_idx_s == 2'(NREQ - 1)) ? 2'd0 : grant_idx_s + 2'd1;
            end else if (rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
            if (xfer_s && (op_count_r != 16'hFFFF)) begin
                op_count_r <= op_count_r + 16'd1;
            end else begin
                op_count_r <= op_count_r;
            end
        end
    end

    assign req_ready  = grant_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//   Directed self-checking bench for alu_share_arb with NREQ=2. Inputs change
//   1ns after the rising edge; outputs are sampled 1ns after the rising edge
//   (registered values) or 1ns after an input change (combinational grant).
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_fun;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        rsp_ready;
    logic [15:0] op_count;

    int n_checks;
    int n_fail;

    localparam logic [3:0]  T_FUN [10] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                           4'b0110, 4'b0111, 4'b1001, 4'b1000, 4'b0000};
    localparam logic [31:0] T_A   [10] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                           32'h80000000, 32'hF0000000, 32'hFF00FF00,
                                           32'h12345678, 32'h3, 32'hFFFFFFFF};
    localparam logic [31:0] T_B   [10] = '{32'h4, 32'h0, 32'h0, 32'hFF00FF00, 32'h4,
                                           32'h0000000F, 32'h0FF00FF0, 32'h9, 32'h5, 32'h1};
    localparam logic [31:0] T_EXP [10] = '{32'h10, 32'h1, 32'h0, 32'h0FF00FF0, 32'h08000000,
                                           32'hF000000F, 32'h0F000F00, 32'h12345678,
                                           32'hFFFFFFFE, 32'h0};

    alu_share_arb #(.NREQ(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_fun    (req_fun),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .op_count   (op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] fun,
                           input logic [31:0] a, input logic [31:0] b);
        req_fun[4*i +: 4]  = fun;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    task automatic do_reset;
        RST_N     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset;
        RST_N     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_req(0, 4'b0000, 32'd1, 32'd1);
        set_req(1, 4'b0000, 32'd2, 32'd2);
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", rsp_valid); end
        n_checks++;
        if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        n_checks++;
        if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", rsp_result); end
        n_checks++;
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", rsp_err); end
        n_checks++;
        if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", op_count); end
        n_checks++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
        req_valid = 2'b00;
        RST_N     = 1'b1;
        tick();
    endtask

    task automatic test_single_op;
        do_reset();
        set_req(0, 4'b0000, 32'd5, 32'd3);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", rsp_valid); end
        n_checks++;
        if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d want 0", rsp_id); end
        n_checks++;
        if (rsp_result !== 32'd8) begin n_fail++; $display("FAIL single_result got %h want 8", rsp_result); end
        n_checks++;
        if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", op_count); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_res;
        do_reset();
        set_req(0, 4'b1000, 32'd10, 32'd4);
        set_req(1, 4'b1101, 32'h80000000, 32'd4);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = ((k % 2) == 0) ? 2'b01 : 2'b10;
            exp_res = ((k % 2) == 0) ? 32'd6 : 32'hF8000000;
            #1;
            n_checks++;
            if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
            tick();
            n_checks++;
            if (rsp_id !== 2'(k % 2)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", k, rsp_id, k % 2); end
            n_checks++;
            if (rsp_result !== exp_res) begin n_fail++; $display("FAIL rr_result[%0d] got %h want %h", k, rsp_result, exp_res); end
        end
        req_valid = 2'b00;
        n_checks++;
        if (op_count !== 16'd4) begin n_fail++; $display("FAIL rr_count got %0d want 4", op_count); end
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        set_req(0, 4'b1000, 32'd10, 32'd4);
        set_req(1, 4'b1101, 32'h80000000, 32'd4);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first_ready got %b want 01", req_ready); end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got %b want 00", k, req_ready); end
            n_checks++;
            if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd0) || (rsp_result !== 32'd6)) begin
                n_fail++;
                $display("FAIL bp_frozen[%0d] got v=%0b id=%0d res=%h want v=1 id=0 res=6", k, rsp_valid, rsp_id, rsp_result);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_resume_ready got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd1) || (rsp_result !== 32'hF8000000)) begin
            n_fail++;
            $display("FAIL bp_resume_rsp got v=%0b id=%0d res=%h want v=1 id=1 res=f8000000", rsp_valid, rsp_id, rsp_result);
        end
        n_checks++;
        if (op_count !== 16'd2) begin n_fail++; $display("FAIL bp_count got %0d want 2", op_count); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", rsp_valid); end
    endtask

    task automatic test_alu_ops;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_req(1, T_FUN[k], T_A[k], T_B[k]);
            req_valid = 2'b10;
            #1;
            n_checks++;
            if (req_ready !== 2'b10) begin n_fail++; $display("FAIL alu_ready[%0d] got %b want 10", k, req_ready); end
            tick();
            n_checks++;
            if ((rsp_result !== T_EXP[k]) || (rsp_id !== 2'd1) || (rsp_err !== 1'b0)) begin
                n_fail++;
                $display("FAIL alu_op[%0d] fun=%b got res=%h id=%0d err=%0b want res=%h id=1 err=0",
                         k, T_FUN[k], rsp_result, rsp_id, rsp_err, T_EXP[k]);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_illegal_op;
        logic exp_err;
`ifdef ALU_SHARE_ARB_OPCHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        set_req(0, 4'b1100, 32'd7, 32'd7);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL illegal_ready got %b want 01", req_ready); end
        tick();
        n_checks++;
        if ((rsp_err !== exp_err) || (rsp_result !== 32'd0) || (rsp_valid !== 1'b1)) begin
            n_fail++;
            $display("FAIL illegal_rsp got err=%0b res=%h v=%0b want err=%0b res=0 v=1", rsp_err, rsp_result, rsp_valid, exp_err);
        end
        set_req(0, 4'b0111, 32'd7, 32'd7);
        tick();
        req_valid = 2'b00;
        n_checks++;
        if ((rsp_err !== 1'b0) || (rsp_result !== 32'd7)) begin
            n_fail++;
            $display("FAIL legal_after_illegal got err=%0b res=%h want err=0 res=7", rsp_err, rsp_result);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_req(0, 4'b0000, 32'd5, 32'd3);
        set_req(1, 4'b0000, 32'd9, 32'd9);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_held got %0b want 1", rsp_valid); end
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ((rsp_valid !== 1'b0) || (op_count !== 16'd0) || (req_ready !== 2'b00)) begin
            n_fail++;
            $display("FAIL mid_async got v=%0b cnt=%0d rdy=%b want v=0 cnt=0 rdy=00", rsp_valid, op_count, req_ready);
        end
        tick();
        RST_N     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if ((rsp_id !== 2'd0) || (rsp_result !== 32'd8) || (op_count !== 16'd1)) begin
            n_fail++;
            $display("FAIL mid_resume got id=%0d res=%h cnt=%0d want id=0 res=8 cnt=1", rsp_id, rsp_result, op_count);
        end
        tick();
    endtask

    task automatic test_saturation;
        do_reset();
        set_req(0, 4'b0000, 32'd1, 32'd1);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        for (int k = 0; k < 65534; k++) begin
            tick();
        end
        n_checks++;
        if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h want fffe", op_count); end
        tick();
        n_checks++;
        if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit got %h want ffff", op_count); end
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        n_checks++;
        if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", op_count); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RST_N     = 1'b0;
        req_valid = 2'b00;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_fun   = 8'd0;
        rsp_ready = 1'b0;
        #2;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_alu_ops();
        test_illegal_op();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and response register that shares one combinational ALU (4-bit `ALU_fun` encoding) between up to four requesters. Each requester presents operands and an op code with a valid/ready handshake. The block grants one request per cycle, instantiates the ALU internally, and returns the registered result tagged with the requester ID through a single valid/ready response channel. It sits between multi-issue or coprocessor front ends and the shared execute datapath.

## Interface
- `NREQ`, 2: number of requesters; legal values 2..4.
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B; same slicing.
- `req_fun`  in  4*NREQ  ALU op code; requester i uses bits [4i+3:4i].
- `req_ready`  out  NREQ  grant; at most one bit set per cycle.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_id`  out  2  index of the requester that owns the response.
- `rsp_result`  out  32  ALU result.
- `rsp_err`  out  1  illegal op code flag; see Configuration.
- `rsp_ready`  in  1  consumer accepts the response.
- `op_count`  out  16  saturating count of accepted requests.

## Operation
- Op codes: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1001 copy A, 1101 sra. Codes 1010, 1011, 1100, 1110, 1111 are illegal and the ALU produces 0 for them.
- Slot free = `!rsp_valid || rsp_ready`.
- Arbitration is combinational. If the slot is free, the first requester with `req_valid` set is granted, searching from `ptr` upward modulo NREQ. `req_ready` is one-hot on that requester, else all zero.
- Transfer occurs when `req_valid[i] && req_ready[i]`. The granted payload feeds the ALU. The result, ID and err are captured at the next rising edge, and `rsp_valid` is set.
- `ptr` update: on a transfer from requester i, `ptr` becomes (i+1) mod NREQ. With no transfer, `ptr` holds.
- Response drain: if `rsp_valid && rsp_ready` and there is no new transfer, `rsp_valid` clears at the next edge. A drain and a new transfer in the same cycle replace the register contents, and `rsp_valid` stays high.
- Response stability: while `rsp_valid && !rsp_ready`, `rsp_id`, `rsp_result` and `rsp_err` hold unchanged and all `req_ready` bits are 0.
- Requester obligation: once `req_valid[i]` is asserted, the requester holds it and keeps the payload stable until `req_ready[i]`. The arbiter does not check this.
- `op_count` increments by 1 per transfer and saturates at 16'hFFFF.
- Reset: `RST_N` low asynchronously clears the following immediately:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0;
  - `ptr`=0, `op_count`=0, and `req_ready`=0 while reset is held.
  A held result is discarded when reset occurs mid-operation. Operation resumes on the first edge after `RST_N` deasserts.

## Timing
- Latency: a request transferred in cycle N has `rsp_valid` high in cycle N+1.
- Throughput: 1 op/cycle while `rsp_ready` stays high. There are no bubbles between back-to-back grants.
- Backpressure: when `rsp_ready` is low and `rsp_valid` is high, no new grants are issued. The first grant after the stall occurs in the cycle `rsp_ready` rises.
- Fairness: with all NREQ requesters continuously valid and no stall, grants rotate 0,1,...,NREQ-1,0. Any requester waits at most NREQ-1 grants.
- The `req_ready` path depends on `req_valid`, `rsp_valid`, `rsp_ready` and `ptr` only, never on operand or op code values.

## Configuration
- `ALU_SHARE_ARB_OPCHECK_EN` defined:
  - an illegal op code is still accepted and arbitrated normally;
  - its response has `rsp_err`=1 and `rsp_result`=32'h0;
  - legal codes give `rsp_err`=0.
- Not defined: `rsp_err` is tied to 0, and `rsp_result` is whatever the ALU produces.

## Test plan
- Single op: after reset, req0 {A=5, B=3, fun=0000} with `rsp_ready`=1 → req_ready=01 in that cycle. Next cycle: rsp_valid=1, rsp_id=0, rsp_result=8, op_count=1.
- Round-robin (NREQ=2): both requesters held valid for 4 ops, with req0 sub 10−4 and req1 sra 32'h80000000 by 4 → rsp_id sequence 0,1,0,1, results 6 and 32'hF8000000 alternating.
- Backpressure: `rsp_ready`=0 for 3 cycles with both requesters valid → rsp fields frozen, req_ready=00. When `rsp_ready` rises, the next grant issues in the same cycle, with no lost or duplicated response.
- Illegal op with macro defined: fun=1100, A=7, B=7 → rsp_err=1, rsp_result=0. Without macro: rsp_err=0.
- Reset mid-operation: drop `RST_N` while rsp_valid=1 with rsp_ready=0 → rsp_valid=0 and op_count=0 immediately. After release, the first grant goes to req0.
- Saturation: 65540 back-to-back ops → op_count stops at 16'hFFFF.
